// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
// Module      : config_loader
// Description : Streams 32-bit host words LSB-first into a serial config chain.
// Revision    : 1.0 - initial release
// ============================================================================
module config_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int CLR_CYC   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        word_ready,
    output logic        cfg_reset,
    output logic        cfg_shift,
    output logic        cfg_data,
    output logic        busy,
    output logic        done
);

    localparam int c_cnt_w = $clog2(CHAIN_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(CHAIN_LEN - 1);
    localparam logic [3:0]         c_clr_last = 4'(CLR_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FETCH = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [3:0]           r_clr_cnt, w_clr_cnt_nxt;
    logic [c_cnt_w-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [4:0]           r_word_bit, w_word_bit_nxt;
    logic [31:0]          r_sreg, w_sreg_nxt;
    logic                 r_word_ready, r_cfg_reset, r_cfg_shift, r_cfg_data, r_busy, r_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_clr_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_word_bit   <= '0;
            r_sreg       <= '0;
            r_word_ready <= 1'b0;
            r_cfg_reset  <= 1'b0;
            r_cfg_shift  <= 1'b0;
            r_cfg_data   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_clr_cnt    <= w_clr_cnt_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_word_bit   <= w_word_bit_nxt;
            r_sreg       <= w_sreg_nxt;
            r_word_ready <= (w_state_nxt == S_FETCH);
            r_cfg_reset  <= (w_state_nxt == S_CLEAR);
            r_cfg_shift  <= (w_state_nxt == S_SHIFT);
            r_cfg_data   <= (w_state_nxt == S_SHIFT) ? w_sreg_nxt[0] : 1'b0;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_done       <= (w_state_nxt == S_DONE);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_cnt_nxt  = r_clr_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_word_bit_nxt = r_word_bit;
        w_sreg_nxt     = r_sreg;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            S_CLEAR: begin
                w_bit_cnt_nxt  = '0;
                w_word_bit_nxt = '0;
                if (r_clr_cnt == c_clr_last) w_state_nxt = S_FETCH;
                else                         w_clr_cnt_nxt = r_clr_cnt + 4'd1;
            end
            S_FETCH: begin
                if (word_valid && r_word_ready) begin
                    w_sreg_nxt     = word_data;
                    w_word_bit_nxt = '0;
                    w_state_nxt    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Bit 0 wraps to the top; wrapped bits are never emitted before the next reload.
                w_sreg_nxt     = {r_sreg[0], r_sreg[31:1]};
                w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
                w_word_bit_nxt = r_word_bit + 5'd1;
                if (r_bit_cnt == c_last_bit)  w_state_nxt = S_DONE;
                else if (r_word_bit == 5'd31) w_state_nxt = S_FETCH;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
    end

    assign word_ready = r_word_ready;
    assign cfg_reset  = r_cfg_reset;
    assign cfg_shift  = r_cfg_shift;
    assign cfg_data   = r_cfg_data;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_config_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_config_loader
// Description : Directed self-checking bench for config_loader (64- and 40-bit chains).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_config_loader;

    logic        clk = 1'b0;
    logic        reset, start_a, start_b, abort, word_valid;
    logic [31:0] word_data;
    logic        rdy_a, crst_a, csh_a, cdat_a, busy_a, done_a;
    logic        rdy_b, crst_b, csh_b, cdat_b, busy_b, done_b;

    always #5 clk = ~clk;

    config_loader #(.CHAIN_LEN(64), .CLR_CYC(2)) u_dut (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort),
        .word_valid(word_valid), .word_data(word_data), .word_ready(rdy_a),
        .cfg_reset(crst_a), .cfg_shift(csh_a), .cfg_data(cdat_a),
        .busy(busy_a), .done(done_a)
    );

    config_loader #(.CHAIN_LEN(40), .CLR_CYC(2)) u_dut40 (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort),
        .word_valid(word_valid), .word_data(word_data), .word_ready(rdy_b),
        .cfg_reset(crst_b), .cfg_shift(csh_b), .cfg_data(cdat_b),
        .busy(busy_b), .done(done_b)
    );

    int checks = 0;
    int errors = 0;

    // scenario setup
    logic [31:0] words [0:3];
    int n_words, stall_word, stall_len, abort_at, restart_cyc;
    // scenario results
    int shifts, dones, done_cycle, clr_cycles, clr_first, first_shift;
    int end_cycle, abort_cycle, stall_cnt, stall_viol, data_viol, rdy_w1;
    logic end_shift;
    logic [127:0] bits;

    task automatic setup(input logic [31:0] w0, input logic [31:0] w1, input int n);
        words[0] = w0; words[1] = w1; words[2] = 32'h0; words[3] = 32'h0;
        n_words = n; stall_word = -1; stall_len = 0; abort_at = -1; restart_cyc = -1;
    endtask

    task automatic run_load(input bit use40, input int max_cyc);
        int acc, pending;
        bit aborted;
        logic s_rdy, s_crst, s_csh, s_cdat, s_busy, s_done;
        acc = 0; pending = 0; aborted = 0;
        shifts = 0; dones = 0; done_cycle = -1; clr_cycles = 0; clr_first = -1;
        first_shift = -1; end_cycle = -1; abort_cycle = -1; stall_cnt = 0;
        stall_viol = 0; data_viol = 0; rdy_w1 = 0; end_shift = 1'b0; bits = '0;
        @(negedge clk);
        if (use40) start_b = 1'b1; else start_a = 1'b1;
        word_valid = 1'b0;
        word_data  = words[0];
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(negedge clk);
            start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
            acc += pending; pending = 0;
            s_rdy  = use40 ? rdy_b  : rdy_a;
            s_crst = use40 ? crst_b : crst_a;
            s_csh  = use40 ? csh_b  : csh_a;
            s_cdat = use40 ? cdat_b : cdat_a;
            s_busy = use40 ? busy_b : busy_a;
            s_done = use40 ? done_b : done_a;
            if (s_crst) begin
                clr_cycles++;
                if (clr_first < 0) clr_first = cyc;
            end
            if (s_csh) begin
                if (first_shift < 0) first_shift = cyc;
                if (shifts < 128) bits[shifts] = s_cdat;
                shifts++;
            end else if (s_cdat) begin
                data_viol++;
            end
            if (s_done) begin
                dones++; done_cycle = cyc;
            end
            if (!s_busy) begin
                end_cycle = cyc; end_shift = s_csh;
                break;
            end
            if (acc == 1 && s_rdy) rdy_w1++;
            if (acc == stall_word && s_rdy && stall_cnt < stall_len) begin
                word_valid = 1'b0;
                stall_cnt++;
                if (s_csh) stall_viol++;
            end else begin
                word_valid = (acc < n_words);
            end
            word_data = words[acc & 3];
            if (s_rdy && word_valid) pending = 1;
            if (abort_at >= 0 && !aborted && shifts == abort_at) begin
                abort = 1'b1; aborted = 1; abort_cycle = cyc;
            end
            if (cyc == restart_cyc) begin
                if (use40) start_b = 1'b1; else start_a = 1'b1;
            end
        end
        word_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
            if (use40 ? done_b : done_a) dones++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        word_valid = 1'b0; word_data = 32'h0;
        #2;
        checks++;
        if ({rdy_a, crst_a, csh_a, cdat_a, busy_a, done_a} !== 6'b0) begin
            errors++; $display("FAIL reset_a got %b expected 000000", {rdy_a, crst_a, csh_a, cdat_a, busy_a, done_a});
        end
        checks++;
        if ({rdy_b, crst_b, csh_b, cdat_b, busy_b, done_b} !== 6'b0) begin
            errors++; $display("FAIL reset_b got %b expected 000000", {rdy_b, crst_b, csh_b, cdat_b, busy_b, done_b});
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_64();
        setup(32'hA5A5A5A5, 32'h0000FFFF, 2);
        run_load(1'b0, 200);
        checks++; if (end_cycle !== 70) begin errors++; $display("FAIL basic_end got %0d expected 70", end_cycle); end
        checks++; if (clr_cycles !== 2 || clr_first !== 1) begin errors++; $display("FAIL basic_clear got %0d@%0d expected 2@1", clr_cycles, clr_first); end
        checks++; if (first_shift !== 4) begin errors++; $display("FAIL basic_first_shift got %0d expected 4", first_shift); end
        checks++; if (shifts !== 64) begin errors++; $display("FAIL basic_shifts got %0d expected 64", shifts); end
        checks++; if (bits[63:0] !== 64'h0000FFFF_A5A5A5A5) begin errors++; $display("FAIL basic_bits got %h expected 0000ffffa5a5a5a5", bits[63:0]); end
        checks++; if (dones !== 1 || done_cycle !== 69) begin errors++; $display("FAIL basic_done got %0d@%0d expected 1@69", dones, done_cycle); end
        checks++; if (data_viol !== 0) begin errors++; $display("FAIL basic_data_idle got %0d expected 0", data_viol); end
    endtask

    task automatic test_truncate_40();
        setup(32'hFFFFFFFF, 32'h000000FF, 2);
        run_load(1'b1, 200);
        checks++; if (end_cycle !== 46) begin errors++; $display("FAIL trunc_end got %0d expected 46", end_cycle); end
        checks++; if (shifts !== 40) begin errors++; $display("FAIL trunc_shifts got %0d expected 40", shifts); end
        checks++; if (bits[47:0] !== 48'h00FF_FFFFFFFF) begin errors++; $display("FAIL trunc_bits got %h expected 00ffffffffff", bits[47:0]); end
        checks++; if (dones !== 1 || done_cycle !== 45) begin errors++; $display("FAIL trunc_done got %0d@%0d expected 1@45", dones, done_cycle); end
    endtask

    task automatic test_stall();
        setup(32'h12345678, 32'h9ABCDEF0, 2);
        stall_word = 1; stall_len = 10;
        run_load(1'b0, 200);
        checks++; if (stall_cnt !== 10 || rdy_w1 !== 11) begin errors++; $display("FAIL stall_ready got %0d/%0d expected 10/11", stall_cnt, rdy_w1); end
        checks++; if (stall_viol !== 0) begin errors++; $display("FAIL stall_shift got %0d expected 0", stall_viol); end
        checks++; if (bits[63:0] !== 64'h9ABCDEF0_12345678) begin errors++; $display("FAIL stall_bits got %h expected 9abcdef012345678", bits[63:0]); end
        checks++; if (dones !== 1 || done_cycle !== 79) begin errors++; $display("FAIL stall_done got %0d@%0d expected 1@79", dones, done_cycle); end
    endtask

    task automatic test_abort();
        setup(32'hA5A5A5A5, 32'h0000FFFF, 2);
        abort_at = 20;
        run_load(1'b0, 200);
        checks++; if (abort_cycle !== 23 || end_cycle !== 24) begin errors++; $display("FAIL abort_idle got %0d->%0d expected 23->24", abort_cycle, end_cycle); end
        checks++; if (shifts !== 20 || end_shift !== 1'b0) begin errors++; $display("FAIL abort_shift got %0d/%b expected 20/0", shifts, end_shift); end
        checks++; if (dones !== 0) begin errors++; $display("FAIL abort_done got %0d expected 0", dones); end
        setup(32'hC3C3C3C3, 32'h0F0F0F0F, 2);
        run_load(1'b0, 200);
        checks++; if (bits[63:0] !== 64'h0F0F0F0F_C3C3C3C3 || shifts !== 64) begin errors++; $display("FAIL abort_reload got %h/%0d expected 0f0f0f0fc3c3c3c3/64", bits[63:0], shifts); end
        checks++; if (dones !== 1 || done_cycle !== 69) begin errors++; $display("FAIL abort_reload_done got %0d@%0d expected 1@69", dones, done_cycle); end
    endtask

    task automatic test_start_while_busy();
        setup(32'h00000001, 32'h80000000, 2);
        restart_cyc = 30;
        run_load(1'b0, 200);
        checks++; if (dones !== 1 || done_cycle !== 69 || end_cycle !== 70) begin errors++; $display("FAIL busy_start got %0d@%0d end %0d expected 1@69 end 70", dones, done_cycle, end_cycle); end
        checks++; if (bits[63:0] !== 64'h80000000_00000001) begin errors++; $display("FAIL busy_start_bits got %h expected 8000000000000001", bits[63:0]); end
    endtask

    task automatic test_idle_abort();
        @(negedge clk); start_a = 1'b1; abort = 1'b1;
        @(negedge clk); start_a = 1'b0; abort = 1'b0;
        checks++; if (busy_a !== 1'b0 || crst_a !== 1'b0) begin errors++; $display("FAIL idle_start_abort got %b%b expected 00", busy_a, crst_a); end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_abort got %b expected 0", busy_a); end
    endtask

    task automatic test_reset_mid_shift();
        int seen, extra_done;
        seen = 0; extra_done = 0;
        @(negedge clk); start_a = 1'b1; word_valid = 1'b1; word_data = 32'hFFFFFFFF;
        @(negedge clk); start_a = 1'b0;
        for (int i = 0; i < 20 && seen < 5; i++) begin
            @(negedge clk);
            if (csh_a) seen++;
        end
        checks++; if (seen !== 5 || cdat_a !== 1'b1) begin errors++; $display("FAIL rst_pre got %0d/%b expected 5/1", seen, cdat_a); end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({rdy_a, crst_a, csh_a, cdat_a, busy_a, done_a} !== 6'b0) begin
            errors++; $display("FAIL rst_async got %b expected 000000", {rdy_a, crst_a, csh_a, cdat_a, busy_a, done_a});
        end
        @(negedge clk); reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (busy_a || done_a || csh_a) extra_done++;
        end
        word_valid = 1'b0;
        checks++; if (extra_done !== 0) begin errors++; $display("FAIL rst_resume got %0d expected 0", extra_done); end
    endtask

    initial begin
        test_reset();
        test_basic_64();
        test_truncate_40();
        test_stall();
        test_abort();
        test_start_while_busy();
        test_idle_abort();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
